bc_polinomio: RTL and testbench
===============================

BC_POLINOMIO -- requirements
Module: bc_polinomio

Interface
REQ-001 SHALL have parameter MUL_H, default 1'b1: value of h that selects ULA multiply; ~MUL_H selects add.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to compute resultado = a*x*x + b*x + c in the paired BO.
REQ-005 SHALL have ports m0, m1, m2, output, 2 each, the BO mux selects.
REQ-006 SHALL have ports lx, ls, lh, output, 1 each, the BO register load enables for X, S and H.
REQ-007 SHALL have port h, output, 1, the BO ULA operation select.
REQ-008 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse marking resultado valid.

Function
REQ-010 SHALL be a Moore FSM; all outputs decode from the state register only.
REQ-011 SHALL drive m0=m1=m2=00, lx=ls=lh=0, h=~MUL_H and done=0 in any state unless the state's entry below says otherwise.
REQ-012 SHALL cycle in state IDLE; start=1 sampled in IDLE -> LOADX, otherwise remain in IDLE.
REQ-013 SHALL drive lx=1 in LOADX, then go to S1.
REQ-014 SHALL compute H=A*X in S1: m0=01, m2=01, m1=01, h=MUL_H, lh=1; then go to S2.
REQ-015 SHALL compute H=H*X in S2: m2=11, m1=01, h=MUL_H, lh=1; then go to S3.
REQ-016 SHALL compute S=B*X in S3: m0=10, m2=01, m1=01, h=MUL_H, ls=1; then go to S4.
REQ-017 SHALL compute S=S+H in S4: m2=10, m1=11, h=~MUL_H, ls=1; then go to S5.
REQ-018 SHALL compute S=S+C in S5: m0=11, m1=00, m2=10, h=~MUL_H, ls=1; then go to DONE.
REQ-019 SHALL drive done=1 in DONE, then go to IDLE unconditionally.
REQ-020 SHALL assert done exactly 7 cycles after the edge that samples start; resultado is valid from that cycle until the next ls pulse.
REQ-021 SHALL ignore start in every state other than IDLE; the sequence is never restarted or extended.
REQ-022 SHALL hold a start that is high continuously so that it begins a new run on the edge after DONE, giving back-to-back runs with period 8 cycles.
REQ-023 SHALL assert at most one of ls and lh in any cycle; lx SHALL be asserted only in LOADX.
REQ-024 SHALL arithmetic width: 16-bit BO, wrap modulo 2^16; the FSM neither detects nor flags overflow.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, force state to IDLE regardless of current state or start; rst has priority over start.
REQ-026 SHALL, after reset, drive busy=0, done=0, lx=ls=lh=0, m0=m1=m2=00, h=~MUL_H.
REQ-027 SHALL, on reset mid-run, produce no done pulse for the aborted run and issue no further load enables; the BO register contents are left as-is.

Configuration
REQ-028 SHALL, when macro BC_POLINOMIO_ABORT_EN is defined, add input port abort (1 bit); abort=1 at an edge in any state except IDLE -> IDLE, with no done pulse; rst has priority over abort.
REQ-029 SHALL, without BC_POLINOMIO_ABORT_EN, have no abort port and have behaviour identical to REQ-010..REQ-027.

Verification (bench pairs bc_polinomio with a BO model, MUL_H=1)
REQ-030 SHALL check a=2, b=3, c=4, x=5 with a one-cycle start pulse -> done high exactly 7 cycles later and resultado=69.
REQ-031 SHALL check a=16'hFFFF, b=0, c=1, x=2 -> resultado=16'hFFFD, showing modulo 2^16 wrap.
REQ-032 SHALL check start held high for 20 cycles with x=1, a=b=c=1 -> done pulses at cycles 7 and 15, busy falls only in the IDLE cycles between runs, resultado=3 each run.
REQ-033 SHALL check rst=1 asserted in S3 -> IDLE on the next edge, all loads 0, no done; a fresh start then yields the correct result.
REQ-034 SHALL check start pulsed during S2 -> no effect, single done at cycle 7.
REQ-035 SHALL, with BC_POLINOMIO_ABORT_EN defined, check abort=1 in S4 -> IDLE on the next edge, busy=0, no done, S not loaded in later cycles.

Source files
------------

// File: rtl/bc_polinomio.sv
// Control block (Moore FSM) sequencing a 16-bit datapath to compute a*x*x + b*x + c.
// Optional feature: define BC_POLINOMIO_ABORT_EN to add an `abort` input that returns to IDLE.
module bc_polinomio #(
  parameter logic MUL_H = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef BC_POLINOMIO_ABORT_EN
  input  logic       abort,
`endif
  output logic [1:0] m0,
  output logic [1:0] m1,
  output logic [1:0] m2,
  output logic       lx,
  output logic       ls,
  output logic       lh,
  output logic       h,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADX = 3'd1,
    S1    = 3'd2,
    S2    = 3'd3,
    S3    = 3'd4,
    S4    = 3'd5,
    S5    = 3'd6,
    DONE  = 3'd7
  } state_t;

  typedef struct packed {
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       lx;
    logic       ls;
    logic       lh;
    logic       h;
    logic       busy;
    logic       done;
  } ctrl_t;

  state_t state_r;
  state_t nxt_s;
  ctrl_t  ctrl_r;
  logic   abort_s;

  // Control word for each state; outputs are registered from the next state so they track state_r.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c      = '0;
    c.h    = ~MUL_H;
    c.busy = (s != IDLE);
    case (s)
      LOADX: c.lx = 1'b1;
      S1: begin
        c.m0 = 2'b01; c.m2 = 2'b01; c.m1 = 2'b01; c.h = MUL_H; c.lh = 1'b1;
      end
      S2: begin
        c.m2 = 2'b11; c.m1 = 2'b01; c.h = MUL_H; c.lh = 1'b1;
      end
      S3: begin
        c.m0 = 2'b10; c.m2 = 2'b01; c.m1 = 2'b01; c.h = MUL_H; c.ls = 1'b1;
      end
      S4: begin
        c.m2 = 2'b10; c.m1 = 2'b11; c.h = ~MUL_H; c.ls = 1'b1;
      end
      S5: begin
        c.m0 = 2'b11; c.m1 = 2'b00; c.m2 = 2'b10; c.h = ~MUL_H; c.ls = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: c.busy = 1'b0;
    endcase
    return c;
  endfunction

  // Abort request, tied low when the feature is not built in.
`ifdef BC_POLINOMIO_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Next-state selection; start is only honoured in IDLE.
  always_comb begin
    nxt_s = IDLE;
    if (abort_s && (state_r != IDLE)) begin
      nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    nxt_s = start ? LOADX : IDLE;
        LOADX:   nxt_s = S1;
        S1:      nxt_s = S2;
        S2:      nxt_s = S3;
        S3:      nxt_s = S4;
        S4:      nxt_s = S5;
        S5:      nxt_s = DONE;
        DONE:    nxt_s = IDLE;
        default: nxt_s = IDLE;
      endcase
    end
  end

  // State and registered control outputs; rst has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ctrl_r  <= decode(IDLE);
    end else begin
      state_r <= nxt_s;
      ctrl_r  <= decode(nxt_s);
    end
  end

  assign m0   = ctrl_r.m0;
  assign m1   = ctrl_r.m1;
  assign m2   = ctrl_r.m2;
  assign lx   = ctrl_r.lx;
  assign ls   = ctrl_r.ls;
  assign lh   = ctrl_r.lh;
  assign h    = ctrl_r.h;
  assign busy = ctrl_r.busy;
  assign done = ctrl_r.done;

endmodule

// File: tb/tb_bc_polinomio.sv
// Self-checking bench: bc_polinomio paired with a 16-bit BO model, step-based reference and random stimulus.
module tb_bc_polinomio;
  localparam logic MUL_H = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  m0, m1, m2;
  logic        lx, ls, lh, h, busy, done;
`ifdef BC_POLINOMIO_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic [15:0] a = 16'd0, b = 16'd0, c = 16'd0, x = 16'd0;
  logic [15:0] x_r = 16'd0, s_r = 16'd0, h_r = 16'd0;
  int          step = 0;
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic        chk_en = 1'b0;

  always #5 clk = ~clk;

  bc_polinomio #(.MUL_H(MUL_H)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef BC_POLINOMIO_ABORT_EN
    .abort(abort),
`endif
    .m0(m0), .m1(m1), .m2(m2), .lx(lx), .ls(ls), .lh(lh), .h(h),
    .busy(busy), .done(done)
  );

  function automatic logic [15:0] poly(input logic [15:0] pa, pb, pc, px);
    return pa * px * px + pb * px + pc;
  endfunction

  function automatic logic [15:0] sel0(input logic [1:0] s);
    case (s)
      2'b01:   return a;
      2'b10:   return b;
      2'b11:   return c;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] alu_out();
    logic [15:0] op1, op2;
    case (m2)
      2'b01:   op1 = sel0(m0);
      2'b10:   op1 = s_r;
      2'b11:   op1 = h_r;
      default: op1 = 16'd0;
    endcase
    case (m1)
      2'b00:   op2 = sel0(m0);
      2'b01:   op2 = x_r;
      2'b11:   op2 = h_r;
      default: op2 = 16'd0;
    endcase
    return (h == MUL_H) ? op1 * op2 : op1 + op2;
  endfunction

  // BO registers driven by the DUT's control word.
  always @(posedge clk) begin
    if (lx) x_r <= x;
    if (lh) h_r <= alu_out();
    if (ls) s_r <= alu_out();
  end

  // Reference: steps since start accepted (0 idle, 1..7 = LOADX..DONE).
  always @(posedge clk) begin
    if (rst) step <= 0;
`ifdef BC_POLINOMIO_ABORT_EN
    else if (abort && step != 0) step <= 0;
`endif
    else if (step == 0) step <= start ? 1 : 0;
    else if (step == 7) step <= 0;
    else step <= step + 1;
  end

  // Expected {busy,done,lx,ls,lh,h,m0,m1,m2} for a given step.
  function automatic logic [11:0] exp_ctrl(input int s);
    case (s)
      1:       return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ~MUL_H, 2'b00, 2'b00, 2'b00};
      2:       return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, MUL_H,  2'b01, 2'b01, 2'b01};
      3:       return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, MUL_H,  2'b00, 2'b01, 2'b11};
      4:       return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MUL_H,  2'b10, 2'b01, 2'b01};
      5:       return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ~MUL_H, 2'b00, 2'b11, 2'b10};
      6:       return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ~MUL_H, 2'b11, 2'b00, 2'b10};
      7:       return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ~MUL_H, 2'b00, 2'b00, 2'b00};
      default: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ~MUL_H, 2'b00, 2'b00, 2'b00};
    endcase
  endfunction

  // Per-cycle compare against the reference, plus result check in the DONE cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [11:0] got, expv;
      got  = {busy, done, lx, ls, lh, h, m0, m1, m2};
      expv = exp_ctrl(step);
      checks = checks + 1;
      if (got !== expv) begin
        errors = errors + 1;
        $display("FAIL ctrl step=%0d got=%b expected=%b t=%0t", step, got, expv, $time);
      end
      if (step == 7) begin
        checks = checks + 1;
        if (s_r !== poly(a, b, c, x)) begin
          errors = errors + 1;
          $display("FAIL resultado got=%h expected=%h t=%0t", s_r, poly(a, b, c, x), $time);
        end
      end
      if (done === 1'b1) done_cnt = done_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks = checks + 1;
    if (got !== expv) begin
      errors = errors + 1;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, expv, $time);
    end
  endtask

  task automatic set_ops(input logic [15:0] na, nb, nc, nx);
    a = na; b = nb; c = nc; x = nx;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_one(input string name, input logic [15:0] pa, pb, pc, px, input logic [15:0] lit);
    int lat;
    set_ops(pa, pb, pc, px);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      tick();
    end
    check({name, "_latency"}, lat, 32'd7);
    check({name, "_resultado"}, {16'd0, s_r}, {16'd0, lit});
    tick();
  endtask

  initial begin
    int d, pos, pos2, d0;
    logic [15:0] s_snap;
    rst = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_loads", {29'd0, lx, ls, lh}, 32'd0);
    check("reset_h", {31'd0, h}, {31'd0, ~MUL_H});
    check("reset_mux", {26'd0, m0, m1, m2}, 32'd0);
    rst = 1'b0;
    tick();

    run_one("basic", 16'd2, 16'd3, 16'd4, 16'd5, 16'd69);
    run_one("wrap", 16'hFFFF, 16'd0, 16'd1, 16'd2, 16'hFFFD);

    // start held high for 20 cycles: runs back to back with period 8
    set_ops(16'd1, 16'd1, 16'd1, 16'd1);
    start = 1'b1;
    d = 0; pos = 0; pos2 = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done === 1'b1) begin
        d++;
        if (d == 1) pos = n;
        if (d == 2) pos2 = n;
        check("held_resultado", {16'd0, s_r}, 32'd3);
      end
      check("held_busy", {31'd0, busy}, (n == 8 || n == 16) ? 32'd0 : 32'd1);
    end
    start = 1'b0;
    check("held_done_count", d, 32'd2);
    check("held_done_first", pos, 32'd7);
    check("held_done_second", pos2, 32'd15);
    wait_idle();

    // reset in S3 aborts the run
    set_ops(16'd2, 16'd3, 16'd4, 16'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("s3_ls", {31'd0, ls}, 32'd1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_loads", {29'd0, lx, ls, lh}, 32'd0);
    for (int n = 0; n < 8; n++) tick();
    check("rst_mid_no_done", done_cnt, d0);
    run_one("after_rst", 16'd2, 16'd3, 16'd4, 16'd5, 16'd69);

    // start pulsed in S2 is ignored
    set_ops(16'd1, 16'd2, 16'd3, 16'd4);
    start = 1'b1;
    tick();
    d = 0; pos = 0;
    for (int n = 1; n <= 16; n++) begin
      if (done === 1'b1) begin
        d++;
        if (pos == 0) pos = n;
      end
      start = (n == 3);
      tick();
    end
    start = 1'b0;
    check("s2_start_done_count", d, 32'd1);
    check("s2_start_done_at", pos, 32'd7);
    check("s2_start_resultado", {16'd0, s_r}, 32'd27);

`ifdef BC_POLINOMIO_ABORT_EN
    set_ops(16'd1, 16'd1, 16'd1, 16'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 5; n++) tick();
    check("abort_in_s4", {31'd0, ls}, 32'd1);
    abort = 1'b1;
    d0 = done_cnt;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    s_snap = s_r;
    for (int n = 0; n < 8; n++) tick();
    check("abort_s_held", {16'd0, s_r}, {16'd0, s_snap});
    check("abort_no_done", done_cnt, d0);
`else
    s_snap = 16'd0;
`endif

    // randomized traffic, the per-cycle compare does the checking
    for (int n = 0; n < 600; n++) begin
      if (step == 0)
        set_ops(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      start = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      tick();
    end
    start = 1'b0;
    rst = 1'b0;
    for (int n = 0; n < 10; n++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
